ps2_rx: RTL and testbench

PS/2 device-to-host serial receiver for the Hack keyboard path. It samples the raw PS/2 clock and data pins, filters and deframes each 11-bit frame, and checks odd parity and the stop bit. Each valid byte is presented on scan_code with a one-cycle scan_ready pulse. It sits directly upstream of the scan-code-to-ASCII translator, which edge-detects scan_ready on the same clk.

---
 rtl/ps2_rx_if.sv | 23 ++
 rtl/ps2_rx.sv | 159 +++++++++++++++
 tb/tb_ps2_rx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: raw pins in, decoded byte and status pulses out.
// The receiver uses the slave modport; whatever drives the pins uses master.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       parity_err;
  logic       frame_err;
  logic [1:0] dbg_state;

  // Pulse outputs are single-cycle strobes with no ready back-pressure: a consumer
  // must sample scan_code on the clk edge where scan_ready is high.
  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, scan_ready, parity_err, frame_err, dbg_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, scan_ready, parity_err, frame_err, dbg_state
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the pins, deframes
// 11-bit frames, checks odd parity and stop bit, and strobes each good byte.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic     clk,
  input logic     reset,
  ps2_rx_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic            r_clk_meta, r_clk_sync;
  logic            r_data_meta, r_data_sync;
  logic            r_f_clk, r_f_clk_d;
  logic [7:0]      r_filt_cnt;
  logic            w_fall;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_parity, w_parity_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [7:0]      r_scan_code, w_scan_code_nxt;
  logic            r_scan_ready, w_scan_ready_nxt;
  logic            r_parity_err, w_parity_err_nxt;
  logic            r_frame_err, w_frame_err_nxt;
  logic            w_timeout;

  // Everything here resets to 1 so releasing reset with idle-high pins
  // cannot manufacture a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_f_clk     <= 1'b1;
      r_f_clk_d   <= 1'b1;
      r_filt_cnt  <= 8'd0;
    end else begin
      r_clk_meta  <= bus.ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= bus.ps2_data;
      r_data_sync <= r_data_meta;
      r_f_clk_d   <= r_f_clk;
      if (r_clk_sync == r_f_clk) begin
        r_filt_cnt <= 8'd0;
      end else if (r_filt_cnt == 8'(FILTER_LEN - 1)) begin
        r_f_clk    <= r_clk_sync;
        r_filt_cnt <= 8'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end
    end
  end

  assign w_fall    = r_f_clk_d & ~r_f_clk;
  // A fall on the expiry cycle still counts as progress, so it wins.
  assign w_timeout = (r_state != IDLE) && !w_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_scan_code  <= 8'd0;
      r_scan_ready <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_scan_code  <= w_scan_code_nxt;
      r_scan_ready <= w_scan_ready_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_parity_nxt     = r_parity;
    w_scan_code_nxt  = r_scan_code;
    w_scan_ready_nxt = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    if (r_state == IDLE || w_fall || w_timeout) begin
      w_to_cnt_nxt = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end

    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!r_data_sync) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end
        DATA: begin
          w_shift_nxt[r_bit_cnt] = r_data_sync;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          w_parity_nxt = r_data_sync;
          w_state_nxt  = STOP;
        end
        STOP: begin
          if (!r_data_sync) begin
            w_frame_err_nxt = 1'b1;
          end else if (^{r_shift, r_parity}) begin
            w_scan_code_nxt  = r_shift;
            w_scan_ready_nxt = 1'b1;
          end else begin
            w_parity_err_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_frame_err_nxt = 1'b1;
      w_state_nxt     = IDLE;
      w_shift_nxt     = 8'd0;
    end
  end

  assign bus.scan_code  = r_scan_code;
  assign bus.scan_ready = r_scan_ready;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: hand-built 11-bit frames (LSB = start bit),
// pulse counting monitor, expected-byte queue and a final summary.
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 500;
  localparam int HALF           = 40;

  logic clk;
  logic reset;
  ps2_rx_if bus ();

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: counts pulses and collects every delivered byte
  int         n_ready = 0, n_perr = 0, n_ferr = 0;
  int         last_ready_cyc = 0, last_ferr_cyc = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.scan_ready) begin
        n_ready++;
        last_ready_cyc = cyc;
        got_q.push_back(bus.scan_code);
      end
      if (bus.parity_err) n_perr++;
      if (bus.frame_err) begin
        n_ferr++;
        last_ferr_cyc = cyc;
      end
    end
  end

  // scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         last_fall_cyc = 0;
  int         b_ready, b_perr, b_ferr, b_got;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_ready = n_ready;
    b_perr  = n_perr;
    b_ferr  = n_ferr;
    b_got   = got_q.size();
  endtask

  task automatic check_deltas(input string tag, input int r, input int p, input int f);
    check({tag, "_ready"}, n_ready - b_ready, r);
    check({tag, "_perr"},  n_perr - b_perr, p);
    check({tag, "_ferr"},  n_ferr - b_ferr, f);
  endtask

  task automatic check_bytes(input string tag);
    int k;
    k = b_got;
    while (exp_q.size() > 0) begin
      if (k < got_q.size()) check({tag, "_byte"}, got_q[k], exp_q[0]);
      else                  check({tag, "_byte_missing"}, 32'hdead, exp_q[0]);
      k++;
      void'(exp_q.pop_front());
    end
  endtask

  // driver: sends the low nbits of a frame; optional short low glitch on one bit
  task automatic send_frame(input logic [10:0] f, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      if (i == glitch_at) begin
        repeat (HALF / 2) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (FILTER_LEN - 2) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF - HALF / 2 - (FILTER_LEN - 2)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.ps2_clk   = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  int lat;

  initial begin
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_code",  bus.scan_code, 8'h00);
    check("rst_ready", bus.scan_ready, 1'b0);
    check("rst_perr",  bus.parity_err, 1'b0);
    check("rst_ferr",  bus.frame_err, 1'b0);
    check("rst_state", bus.dbg_state, 2'd0);
    check("rst_no_pulse", n_ready + n_perr + n_ferr, 0);

    // single 0x1C, parity 0
    snap();
    exp_q.push_back(8'h1C);
    send_frame(11'b1_0_00011100_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("t1", 1, 0, 0);
    check_bytes("t1");
    check("t1_code", bus.scan_code, 8'h1C);
    lat = last_ready_cyc - last_fall_cyc;
    check("t1_latency_window", (lat >= FILTER_LEN + 2) && (lat <= FILTER_LEN + 4), 1'b1);

    // back-to-back 0xF0, 0x1C, 0x12
    snap();
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h12);
    send_frame(11'b1_1_11110000_0, 11, -1);
    send_frame(11'b1_0_00011100_0, 11, -1);
    send_frame(11'b1_1_00010010_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("b2b", 3, 0, 0);
    check_bytes("b2b");

    // 0x1C with parity forced to 1
    snap();
    send_frame(11'b1_1_00011100_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("perr", 0, 1, 0);
    check("perr_code_held", bus.scan_code, 8'h12);

    // 0x1C with stop bit 0 (parity correct)
    snap();
    send_frame(11'b0_0_00011100_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("stop0", 0, 0, 1);
    check("stop0_code_held", bus.scan_code, 8'h12);

    // start + 5 data bits then silence: timeout
    snap();
    send_frame(11'b1_0_00011100_0, 6, -1);
    repeat (TIMEOUT_CYCLES + FILTER_LEN + 40) @(negedge clk);
    check_deltas("tmo", 0, 0, 1);
    lat = last_ferr_cyc - last_fall_cyc;
    check("tmo_latency_window",
          (lat >= TIMEOUT_CYCLES) && (lat <= TIMEOUT_CYCLES + FILTER_LEN + 6), 1'b1);
    check("tmo_state_idle", bus.dbg_state, 2'd0);

    snap();
    exp_q.push_back(8'h29);
    send_frame(11'b1_0_00101001_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("after_tmo", 1, 0, 0);
    check_bytes("after_tmo");

    // 0x58 with a sub-filter clock glitch mid-bit
    snap();
    exp_q.push_back(8'h58);
    send_frame(11'b1_0_01011000_0, 11, 4);
    repeat (HALF) @(negedge clk);
    check_deltas("glitch", 1, 0, 0);
    check_bytes("glitch");

    // reset after the 4th data bit, then a clean 0x1C
    snap();
    send_frame(11'b1_0_00011100_0, 5, -1);
    check("pre_rst_state", bus.dbg_state, 2'd1);
    reset = 1'b1;
    #1;
    check("midrst_code",  bus.scan_code, 8'h00);
    check("midrst_ready", bus.scan_ready, 1'b0);
    check("midrst_state", bus.dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (TIMEOUT_CYCLES + 40) @(negedge clk);
    check_deltas("midrst", 0, 0, 0);

    snap();
    exp_q.push_back(8'h1C);
    send_frame(11'b1_0_00011100_0, 11, -1);
    repeat (HALF) @(negedge clk);
    check_deltas("post_rst", 1, 0, 0);
    check_bytes("post_rst");
    check("post_rst_code", bus.scan_code, 8'h1C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
